// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: handshake front/back end around combinational FP add/mul/div
// units. Screens special operands, orders add operands by magnitude, holds unit
// inputs for a per-op multicycle settle window, then registers the result.
module fpu_op_sequencer #(
  parameter int unsigned ADD_WAIT = 1,
  parameter int unsigned MUL_WAIT = 1,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_dbz
);

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;
  localparam logic [1:0]  OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;
  logic               flag_invalid_q, flag_invalid_d;
  logic               flag_dbz_q, flag_dbz_d;
  logic [31:0]        unit_a_q, unit_a_d;
  logic [31:0]        unit_b_q, unit_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;

  // Screening of the incoming operation
  logic [31:0]      b_eff;
  logic             sx;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  logic             spec_hit;
  logic [31:0]      spec_res;
  logic             spec_inv;
  logic             spec_dbz;
  logic [31:0]      ua_c, ub_c;
  logic [CNT_W-1:0] wait_c;

  // Classify operands, resolve special results, and pick unit operand order
  always_comb begin
    b_eff    = (op == OP_SUB) ? {~b[31], b[30:0]} : b;
    sx       = a[31] ^ b_eff[31];
    a_zero   = (a[30:23] == 8'h00);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_zero   = (b_eff[30:23] == 8'h00);
    b_inf    = (b_eff[30:23] == 8'hFF) && (b_eff[22:0] == 23'h0);
    b_nan    = (b_eff[30:23] == 8'hFF) && (b_eff[22:0] != 23'h0);
    spec_hit = 1'b0;
    spec_res = 32'h0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    ua_c     = a;
    ub_c     = b;
    wait_c   = CNT_W'(ADD_WAIT);

    if (a_nan || b_nan) begin
      spec_hit = 1'b1;
      spec_res = QNAN;
    end else begin
      case (op)
        OP_DIV: begin
          spec_hit = a_zero || b_zero || a_inf || b_inf;
          if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
          end else if (!a_zero && !a_inf && b_zero) begin
            spec_res = {sx, 8'hFF, 23'h0};
            spec_dbz = 1'b1;
          end else if (a_zero || b_inf) begin
            spec_res = {sx, 31'h0};
          end else if (a_inf) begin
            spec_res = {sx, 8'hFF, 23'h0};
          end
        end
        OP_MUL: begin
          spec_hit = a_zero || b_zero || a_inf || b_inf;
          if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
          end else if (a_zero || b_zero) begin
            spec_res = {sx, 31'h0};
          end else if (a_inf || b_inf) begin
            spec_res = {sx, 8'hFF, 23'h0};
          end
        end
        OP_ADD, OP_SUB: begin
          if (a_inf && b_inf && (a[31] != b_eff[31])) begin
            spec_hit = 1'b1;
            spec_res = QNAN;
            spec_inv = 1'b1;
          end else if (a_zero) begin
            spec_hit = 1'b1;
            spec_res = b_eff;
          end else if (b_zero) begin
            spec_hit = 1'b1;
            spec_res = a;
          end else if ((a[30:0] == b_eff[30:0]) && (a[31] != b_eff[31])) begin
            spec_hit = 1'b1;
            spec_res = 32'h0;
          end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_res = a;
          end else if (b_inf) begin
            spec_hit = 1'b1;
            spec_res = b_eff;
          end
        end
        default: spec_hit = 1'b0;
      endcase
    end

    // The adder needs the larger magnitude (hence exponent) on its A input
    if ((op == OP_ADD) || (op == OP_SUB)) begin
      if (b_eff[30:0] > a[30:0]) begin
        ua_c = b_eff;
        ub_c = a;
      end else begin
        ua_c = a;
        ub_c = b_eff;
      end
    end

    case (op)
      OP_MUL:  wait_c = CNT_W'(MUL_WAIT);
      OP_DIV:  wait_c = CNT_W'(DIV_WAIT);
      default: wait_c = CNT_W'(ADD_WAIT);
    endcase
  end

  // Next-state and register-input logic
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    result_d       = result_q;
    flag_invalid_d = flag_invalid_q;
    flag_dbz_d     = flag_dbz_q;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    cnt_d          = cnt_q;
    op_d           = op_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d           = op;
          flag_invalid_d = 1'b0;
          flag_dbz_d     = 1'b0;
          if (spec_hit) begin
            result_d       = spec_res;
            flag_invalid_d = spec_inv;
            flag_dbz_d     = spec_dbz;
            state_d        = RESP;
          end else begin
            unit_a_d = ua_c;
            unit_b_d = ub_c;
            cnt_d    = wait_c;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          case (op_q)
            OP_MUL:  result_d = mul_res;
            OP_DIV:  result_d = div_res;
            default: result_d = add_res;
          endcase
          out_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Special results arrive with out_valid still low; present them one cycle on
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      result_q       <= 32'h0;
      flag_invalid_q <= 1'b0;
      flag_dbz_q     <= 1'b0;
      unit_a_q       <= 32'h0;
      unit_b_q       <= 32'h0;
      cnt_q          <= '0;
      op_q           <= 2'b00;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      flag_invalid_q <= flag_invalid_d;
      flag_dbz_q     <= flag_dbz_d;
      unit_a_q       <= unit_a_d;
      unit_b_q       <= unit_b_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign flag_invalid = flag_invalid_q;
  assign flag_dbz     = flag_dbz_q;
  assign unit_a       = unit_a_q;
  assign unit_b       = unit_b_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with simple stand-in unit models.
module tb_fpu_op_sequencer;

  localparam int unsigned ADD_WAIT = 1;
  localparam int unsigned MUL_WAIT = 1;
  localparam int unsigned DIV_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] unit_a, unit_b;
  logic [31:0] add_res, mul_res, div_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid, flag_dbz;

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  fpu_op_sequencer #(
    .ADD_WAIT(ADD_WAIT), .MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .unit_a(unit_a), .unit_b(unit_b), .add_res(add_res),
    .mul_res(mul_res), .div_res(div_res), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_invalid(flag_invalid),
    .flag_dbz(flag_dbz)
  );

  always #5 clk = ~clk;

  // Stand-in unit models; known pairs give real IEEE answers, others a hash
  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h4040_0000 && y == 32'h3F80_0000) return 32'h4080_0000;
    return x ^ {y[15:0], y[31:16]};
  endfunction
  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction
  function automatic logic [31:0] m_div(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h40C0_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    return x - y;
  endfunction

  assign add_res = m_add(unit_a, unit_b);
  assign mul_res = m_mul(unit_a, unit_b);
  assign div_res = m_div(unit_a, unit_b);

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Scoreboard consumer: compare at each output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        expect_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        expect_eq("result", result, e.res);
        expect_eq("flag_invalid", 32'(flag_invalid), 32'(e.inv));
        expect_eq("flag_dbz", 32'(flag_dbz), 32'(e.dbz));
      end
    end
  end

  // Drive one op, push its expectation, check unit hold and latency
  task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] er, input logic ei, input logic ed,
                        input int elat, input logic chk_u,
                        input logic [31:0] eua, input logic [31:0] eub);
    int   cyc;
    exp_t e;
    @(negedge clk);
    expect_eq("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk);
    e.res = er; e.inv = ei; e.dbz = ed;
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    expect_eq("in_ready_busy", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (chk_u) begin
        expect_eq("unit_a_hold", unit_a, eua);
        expect_eq("unit_b_hold", unit_b, eub);
      end
      @(posedge clk); #1;
      cyc++;
    end
    expect_eq("latency", 32'(cyc), 32'(elat));
    if (chk_u) begin
      expect_eq("unit_a_at_sample", unit_a, eua);
      expect_eq("unit_b_at_sample", unit_b, eub);
    end
    if (out_ready) begin
      @(posedge clk); #1;
      expect_eq("out_valid_drop", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic run_unit(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] bp, ua, ub, r;
    int          w;
    bp = (o == 2'b01) ? {~ib[31], ib[30:0]} : ib;
    ua = ia; ub = ib;
    if (o[1] == 1'b0) begin
      if (bp[30:0] > ia[30:0]) begin ua = bp; ub = ia; end
      else begin ua = ia; ub = bp; end
    end
    case (o)
      2'b10:   begin r = m_mul(ua, ub); w = MUL_WAIT; end
      2'b11:   begin r = m_div(ua, ub); w = DIV_WAIT; end
      default: begin r = m_add(ua, ub); w = ADD_WAIT; end
    endcase
    run_op(o, ia, ib, r, 1'b0, 1'b0, w, 1'b1, ua, ub);
  endtask

  task automatic run_spec(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] er, input logic ei, input logic ed);
    run_op(o, ia, ib, er, ei, ed, 1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;
    #1;
    expect_eq("rst_in_ready", 32'(in_ready), 32'd1);
    expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst_result", result, 32'h0);
    expect_eq("rst_flags", {30'd0, flag_invalid, flag_dbz}, 32'd0);
    expect_eq("rst_unit_a", unit_a, 32'h0);
    expect_eq("rst_unit_b", unit_b, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Directed unit-path and special cases
    run_unit(2'b11, 32'h40C0_0000, 32'h4000_0000);
    run_spec(2'b11, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1);
    run_spec(2'b11, 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1);
    run_spec(2'b11, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_op(2'b00, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000, 1'b0, 1'b0, 1, 1'b1,
           32'h4040_0000, 32'h3F80_0000);
    run_spec(2'b01, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_spec(2'b10, 32'h0000_0000, 32'hC0A0_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_spec(2'b10, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    run_spec(2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_spec(2'b10, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_spec(2'b11, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
    run_spec(2'b11, 32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_spec(2'b11, 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_spec(2'b11, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0);
    run_spec(2'b11, 32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0);
    run_spec(2'b01, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b0);
    run_spec(2'b00, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0, 1'b0);
    run_spec(2'b00, 32'h0000_0001, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_spec(2'b00, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0);
    run_spec(2'b01, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b0);
    run_unit(2'b01, 32'h3F80_0000, 32'h4040_0000);
    run_unit(2'b10, 32'h4000_0000, 32'h4040_0000);

    // Random normal operands through the unit path
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      if (ra[30:0] == rb[30:0]) rb[0] = ~rb[0];
      run_unit(2'($urandom), ra, rb);
    end

    // Backpressure: result held, no capture, handshake releases to IDLE
    out_ready = 1'b0;
    run_unit(2'b10, 32'h4000_0000, 32'h4040_0000);
    held = m_mul(32'h4000_0000, 32'h4040_0000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 2'b00; a = 32'h3F80_0000; b = 32'h0000_0000;
      @(posedge clk); #1;
      expect_eq("bp_out_valid", 32'(out_valid), 32'd1);
      expect_eq("bp_result", result, held);
      expect_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_eq("bp_release_valid", 32'(out_valid), 32'd0);
    expect_eq("bp_release_ready", 32'(in_ready), 32'd1);
    run_unit(2'b00, 32'h4000_0000, 32'h3F80_0000);

    // Reset during a divide discards it
    @(negedge clk);
    op = 2'b11; a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    expect_eq("rst_run_out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst_run_in_ready", 32'(in_ready), 32'd1);
    expect_eq("rst_run_unit_a", unit_a, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    expect_eq("rst_no_result", 32'(seen), 32'd0);
    expect_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
